// File: rtl/acc_feeder.sv
// Streams samples through a fixed-latency function unit into an external accumulator.
// An input FIFO absorbs the issue hold-off; a shift register tracks results still in flight.
module acc_feeder #(
    parameter int LAT     = 8,
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [15:0] cmd_len,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] fn_x,
    input  logic [31:0] fn_fx,
    output logic        acc_start,
    output logic [31:0] acc_data,
    output logic        acc_valid,
    output logic        acc_finished,
    input  logic        acc_done,
    input  logic [31:0] acc_result,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid
);
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    FULL      = (AW+1)'(DEPTH);
    localparam logic [15:0]    HOLD_LAST = 16'(HOLDOFF - 1);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_HOLD   = 6'b000010,
        S_FEED   = 6'b000100,
        S_DRAIN  = 6'b001000,
        S_FINISH = 6'b010000,
        S_WAIT   = 6'b100000
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [15:0]   accepted_q, accepted_d;
    logic [15:0]   issued_q, issued_d;
    logic [15:0]   hold_q, hold_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [31:0]   fn_x_q;
    logic [LAT-1:0] sr_q;
    logic          acc_valid_q;
    logic          acc_start_q, acc_start_d;
    logic [31:0]   result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          push, pop;

    assign in_ready     = (state_q == S_HOLD || state_q == S_FEED) &&
                          (cnt_q != FULL) && (accepted_q < n_q);
    assign push         = in_valid && in_ready;
    assign pop          = (state_q == S_FEED) && (cnt_q != '0);
    assign fn_x         = fn_x_q;
    assign acc_start    = acc_start_q;
    assign acc_valid    = acc_valid_q;
    assign acc_data     = acc_valid_q ? fn_fx : 32'd0;
    assign acc_finished = (state_q == S_FINISH);
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        accepted_d     = accepted_q + 16'(push);
        issued_d       = issued_q + 16'(pop);
        hold_d         = hold_q;
        acc_start_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cmd_len != 16'd0) begin
                        n_d         = cmd_len;
                        accepted_d  = 16'd0;
                        issued_d    = 16'd0;
                        hold_d      = 16'd0;
                        acc_start_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        // Empty job: report a zero sum without touching the accumulator.
                        result_d       = 32'd0;
                        result_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                hold_d = hold_q + 16'd1;
                if (hold_q == HOLD_LAST) state_d = S_FEED;
            end
            S_FEED: begin
                if (pop && (issued_q + 16'd1 == n_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (sr_q == '0) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_WAIT;
            S_WAIT: begin
                if (acc_done) begin
                    result_d       = acc_result;
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            accepted_q     <= '0;
            issued_q       <= '0;
            hold_q         <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            cnt_q          <= '0;
            fn_x_q         <= '0;
            sr_q           <= '0;
            acc_valid_q    <= 1'b0;
            acc_start_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            accepted_q     <= accepted_d;
            issued_q       <= issued_d;
            hold_q         <= hold_d;
            acc_start_q    <= acc_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) begin
                rd_q   <= rd_q + AW'(1);
                fn_x_q <= mem_q[rd_q];
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: ;
            endcase
            // Final register stage aligns acc_valid with fn_fx, LAT cycles after fn_x moves.
            sr_q        <= (sr_q << 1) | LAT'(pop);
            acc_valid_q <= sr_q[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data;
    end
endmodule
